// File: rtl/mci_sram_responder_if.sv
// Request/response bundle between the MCI SRAM requester and the storage-side responder.
// Error-injection arms and status counters travel with the bus so one handle covers a port.
interface mci_sram_responder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int ECC_W  = 7
);
  logic                cs;
  logic                we;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [ECC_W-1:0]    wecc;
  logic [DATA_W/8-1:0] wstrb;
  logic                inj_sbe;
  logic                inj_dbe;
  logic [DATA_W-1:0]   rdata;
  logic [ECC_W-1:0]    recc;
  logic                rvalid;
  logic                oor_err;
  logic [15:0]         rd_cnt;
  logic [15:0]         wr_cnt;

  modport master (
    output cs, we, addr, wdata, wecc, wstrb, inj_sbe, inj_dbe,
    input  rdata, recc, rvalid, oor_err, rd_cnt, wr_cnt
  );

  modport slave (
    input  cs, we, addr, wdata, wecc, wstrb, inj_sbe, inj_dbe,
    output rdata, recc, rvalid, oor_err, rd_cnt, wr_cnt
  );
endinterface

// File: rtl/mci_sram_responder.sv
// Behavioural SRAM responder for the MCI SRAM ports: byte-masked writes with stored ECC,
// fixed-latency reads, sticky SBE/DBE read corruption, out-of-range flagging and counters.
module mci_sram_responder #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int ECC_W  = 7,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic                 clk,
  input logic                 rst,
  mci_sram_responder_if.slave bus
);
  localparam int NB = DATA_W / 8;

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("mci_sram_responder: RD_LAT must be within 1..4");
  end
  if (DATA_W % 8 != 0) begin : g_bad_dw
    $error("mci_sram_responder: DATA_W must be a whole number of bytes");
  end

  logic [DATA_W-1:0] mem_q     [DEPTH];
  logic [ECC_W-1:0]  ecc_mem_q [DEPTH];

  logic              in_range, rd_req, wr_req, consume;
  logic [ADDR_W-1:0] idx;
  logic              arm_sbe_q, arm_sbe_d, arm_dbe_q, arm_dbe_d;
  logic [DATA_W-1:0] flip, s0_data;
  logic [ECC_W-1:0]  s0_ecc;

  logic [RD_LAT-1:0]             vld_pipe_q, vld_pipe_d;
  logic [RD_LAT-1:0][DATA_W-1:0] dat_pipe_q, dat_pipe_d;
  logic [RD_LAT-1:0][ECC_W-1:0]  ecc_pipe_q, ecc_pipe_d;
  logic                          oor_err_q;
  logic [15:0]                   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  assign in_range = {1'b0, bus.addr} < (ADDR_W+1)'(DEPTH);
  assign idx      = in_range ? bus.addr : '0;
  assign rd_req   = ~rst & bus.cs & ~bus.we;
  assign wr_req   = ~rst & bus.cs & bus.we & in_range;
  assign consume  = rd_req & in_range;

  // Storage has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_req) begin
      for (int b = 0; b < NB; b++)
        if (bus.wstrb[b]) mem_q[idx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
      if (|bus.wstrb) ecc_mem_q[idx] <= bus.wecc;
    end
  end

  // Arm inputs seen in the same cycle as a read already apply to it.
  always_comb begin
    arm_sbe_d = arm_sbe_q | bus.inj_sbe;
    arm_dbe_d = arm_dbe_q | bus.inj_dbe;
    flip      = '0;
    if (arm_dbe_d)      flip[1:0] = 2'b11;
    else if (arm_sbe_d) flip[0]   = 1'b1;
    s0_data   = in_range ? (mem_q[idx] ^ flip) : '0;
    s0_ecc    = in_range ? ecc_mem_q[idx] : '0;
    if (consume) begin
      arm_sbe_d = 1'b0;
      arm_dbe_d = 1'b0;
    end
  end

  always_comb begin
    vld_pipe_d    = '0;
    dat_pipe_d    = '0;
    ecc_pipe_d    = '0;
    vld_pipe_d[0] = rd_req;
    dat_pipe_d[0] = s0_data;
    ecc_pipe_d[0] = s0_ecc;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      dat_pipe_d[i] = dat_pipe_q[i-1];
      ecc_pipe_d[i] = ecc_pipe_q[i-1];
    end
    rd_cnt_d = (vld_pipe_d[RD_LAT-1] && rd_cnt_q != 16'hFFFF) ? rd_cnt_q + 16'd1 : rd_cnt_q;
    wr_cnt_d = (wr_req && wr_cnt_q != 16'hFFFF) ? wr_cnt_q + 16'd1 : wr_cnt_q;
  end

  // Data stages load only behind a valid, so the last stage holds the last response.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
      ecc_pipe_q <= '0;
      arm_sbe_q  <= 1'b0;
      arm_dbe_q  <= 1'b0;
      oor_err_q  <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      for (int i = 0; i < RD_LAT; i++)
        if (vld_pipe_d[i]) begin
          dat_pipe_q[i] <= dat_pipe_d[i];
          ecc_pipe_q[i] <= ecc_pipe_d[i];
        end
      arm_sbe_q <= arm_sbe_d;
      arm_dbe_q <= arm_dbe_d;
      oor_err_q <= bus.cs & ~in_range;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  assign bus.rvalid  = vld_pipe_q[RD_LAT-1];
  assign bus.rdata   = dat_pipe_q[RD_LAT-1];
  assign bus.recc    = ecc_pipe_q[RD_LAT-1];
  assign bus.oor_err = oor_err_q;
  assign bus.rd_cnt  = rd_cnt_q;
  assign bus.wr_cnt  = wr_cnt_q;
endmodule

// File: tb/tb_mci_sram_responder.sv
// Three responder configurations driven in lockstep and checked every cycle against
// a queue-based model of the storage, injection arms and response timing.
module tb_mci_sram_responder;
  localparam int AW = 10, DW = 32, EW = 7, NI = 3;
  localparam int DEP [NI] = '{1024, 1000, 1000};
  localparam int LAT [NI] = '{1, 3, 4};

  logic          clk = 1'b0, rst = 1'b1;
  logic          cs = 1'b0, we = 1'b0, inj_sbe = 1'b0, inj_dbe = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [EW-1:0] wecc = '0;
  logic [3:0]    wstrb = '0;

  logic [NI-1:0]         rv, oo;
  logic [NI-1:0][DW-1:0] rd;
  logic [NI-1:0][EW-1:0] re;
  logic [NI-1:0][15:0]   rc, wc;

  always #5 clk = ~clk;

  mci_sram_responder_if #(.ADDR_W(AW), .DATA_W(DW), .ECC_W(EW)) ifs [NI] ();

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign ifs[g].cs      = cs;
    assign ifs[g].we      = we;
    assign ifs[g].addr    = addr;
    assign ifs[g].wdata   = wdata;
    assign ifs[g].wecc    = wecc;
    assign ifs[g].wstrb   = wstrb;
    assign ifs[g].inj_sbe = inj_sbe;
    assign ifs[g].inj_dbe = inj_dbe;
    assign rv[g] = ifs[g].rvalid;
    assign rd[g] = ifs[g].rdata;
    assign re[g] = ifs[g].recc;
    assign oo[g] = ifs[g].oor_err;
    assign rc[g] = ifs[g].rd_cnt;
    assign wc[g] = ifs[g].wr_cnt;
    mci_sram_responder #(.DEPTH(DEP[g]), .DATA_W(DW), .ECC_W(EW), .RD_LAT(LAT[g]), .ADDR_W(AW)) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(ifs[g])
    );
  end

  typedef struct {
    int            k;
    int            due;
    logic [DW-1:0] d;
    logic [EW-1:0] e;
  } resp_t;

  resp_t         pend [$];
  logic [DW-1:0] m_mem [NI][1024];
  logic [EW-1:0] m_ecc [NI][1024];
  logic          e_rv [NI], e_oo [NI], a_s [NI], a_d [NI];
  logic [DW-1:0] e_rd [NI];
  logic [EW-1:0] e_re [NI];
  logic [15:0]   e_rc [NI], e_wc [NI];
  int            cyc = 0, n_cmp = 0, n_bad = 0;

  // Applies one clock edge to instance k using the inputs that edge sampled.
  function automatic void model_edge(int k);
    logic [DW-1:0] d;
    bit            inr;
    if (rst) begin
      for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].k == k) pend.delete(i);
      e_rv[k] = 1'b0; e_rd[k] = '0; e_re[k] = '0; e_oo[k] = 1'b0;
      e_rc[k] = '0;   e_wc[k] = '0; a_s[k] = 1'b0;  a_d[k] = 1'b0;
      return;
    end
    inr     = int'(addr) < DEP[k];
    e_oo[k] = cs && !inr;
    a_s[k]  = a_s[k] | inj_sbe;
    a_d[k]  = a_d[k] | inj_dbe;
    if (cs && we && inr) begin
      for (int b = 0; b < 4; b++) if (wstrb[b]) m_mem[k][addr][8*b +: 8] = wdata[8*b +: 8];
      if (wstrb != 4'h0) m_ecc[k][addr] = wecc;
      if (e_wc[k] != 16'hFFFF) e_wc[k] = e_wc[k] + 16'd1;
    end
    if (cs && !we) begin
      if (inr) begin
        d = m_mem[k][addr];
        if (a_d[k]) d = d ^ 32'h3;
        else if (a_s[k]) d = d ^ 32'h1;
        a_s[k] = 1'b0;
        a_d[k] = 1'b0;
        pend.push_back('{k: k, due: cyc + LAT[k] - 1, d: d, e: m_ecc[k][addr]});
      end else begin
        pend.push_back('{k: k, due: cyc + LAT[k] - 1, d: '0, e: '0});
      end
    end
    e_rv[k] = 1'b0;
    for (int i = 0; i < pend.size(); i++)
      if (pend[i].k == k && pend[i].due == cyc) begin
        e_rv[k] = 1'b1;
        e_rd[k] = pend[i].d;
        e_re[k] = pend[i].e;
        if (e_rc[k] != 16'hFFFF) e_rc[k] = e_rc[k] + 16'd1;
        pend.delete(i);
        break;
      end
  endfunction

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%h exp=%h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NI; k++) begin
      model_edge(k);
      chk("rvalid",  k, rv[k], e_rv[k]);
      chk("rdata",   k, rd[k], e_rd[k]);
      chk("recc",    k, re[k], e_re[k]);
      chk("oor_err", k, oo[k], e_oo[k]);
      chk("rd_cnt",  k, rc[k], e_rc[k]);
      chk("wr_cnt",  k, wc[k], e_wc[k]);
    end
  endtask

  task automatic req(bit c, bit w, int a, logic [31:0] d, logic [6:0] e, logic [3:0] s,
                     bit is = 1'b0, bit id = 1'b0);
    cs = c; we = w; addr = AW'(a); wdata = d; wecc = e; wstrb = s;
    inj_sbe = is; inj_dbe = id;
    step();
  endtask

  task automatic wr(int a, logic [31:0] d, logic [6:0] e, logic [3:0] s);
    req(1'b1, 1'b1, a, d, e, s);
  endtask

  task automatic rdq(int a, bit is = 1'b0, bit id = 1'b0);
    req(1'b1, 1'b0, a, '0, '0, '0, is, id);
  endtask

  task automatic idle(int n = 1, bit is = 1'b0, bit id = 1'b0);
    for (int i = 0; i < n; i++) req(1'b0, 1'b0, 0, '0, '0, '0, (i == 0) ? is : 1'b0, (i == 0) ? id : 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle(2);
    chk("rst_rvalid", 2, rv[2], 0);
    chk("rst_rdata",  1, rd[1], 0);
    chk("rst_rdcnt",  0, rc[0], 0);
    rst = 1'b0;

    // write then read next cycle
    wr(5, 32'hDEADBEEF, 7'h55, 4'hF);
    rdq(5);
    chk("wr_rd_rvalid", 0, rv[0], 1);
    chk("wr_rd_data",   0, rd[0], 32'hDEADBEEF);
    chk("wr_rd_ecc",    0, re[0], 32'h55);
    chk("wr_rd_wcnt",   0, wc[0], 1);
    chk("wr_rd_rcnt",   0, rc[0], 1);

    // zero strobe: counted, storage untouched
    wr(5, 32'h0, 7'h00, 4'h0);
    rdq(5);
    chk("nostrb_data", 0, rd[0], 32'hDEADBEEF);
    chk("nostrb_ecc",  0, re[0], 32'h55);
    chk("nostrb_wcnt", 0, wc[0], 2);

    // byte mask
    wr(7, 32'h11223344, 7'h11, 4'hF);
    wr(7, 32'hAABBCCDD, 7'h22, 4'h5);
    rdq(7);
    chk("bmask_data", 0, rd[0], 32'h11BB33DD);
    chk("bmask_ecc",  0, re[0], 32'h22);
    idle(4);

    // streaming reads, watched on the RD_LAT=3 instance
    for (int i = 0; i < 8; i++) wr(i, 32'hA5000000 | i, 7'(i), 4'hF);
    for (int t = 0; t < 14; t++) begin
      if (t < 8) rdq(t);
      else idle();
      chk("stream_rvalid", 1, rv[1], (t >= 2 && t <= 9) ? 1 : 0);
      if (t >= 2 && t <= 9) chk("stream_data", 1, rd[1], 32'hA5000000 | (t - 2));
    end

    // out of range on DEPTH=1000 instances; in range on the 1024 one
    wr(1000, 32'h12345678, 7'h3C, 4'hF);
    chk("oor_wr_pulse",   1, oo[1], 1);
    chk("oor_wr_inrange", 0, oo[0], 0);
    chk("oor_wr_wcnt",    1, wc[1], 12);
    chk("oor_wr_wcnt_a",  0, wc[0], 13);
    rdq(1000);
    chk("oor_rd_pulse", 2, oo[2], 1);
    chk("oor_rd_a",     0, rd[0], 32'h12345678);
    idle(1);
    chk("oor_clear", 1, oo[1], 0);
    idle(1);
    chk("oor_rd_valid", 1, rv[1], 1);
    chk("oor_rd_data",  1, rd[1], 0);
    chk("oor_rd_ecc",   1, re[1], 0);
    idle(2);

    // error injection
    wr(20, 32'h0, 7'h2A, 4'hF);
    idle(1, 1'b0, 1'b1);
    idle(1);
    rdq(20);
    chk("inj_dbe_data", 0, rd[0], 32'h3);
    chk("inj_dbe_ecc",  0, re[0], 32'h2A);
    rdq(20);
    chk("inj_clear", 0, rd[0], 0);
    rdq(20, 1'b1, 1'b0);
    chk("inj_same_cycle", 0, rd[0], 1);
    idle(1, 1'b1, 1'b0);
    idle(1, 1'b0, 1'b1);
    rdq(20);
    chk("inj_both", 0, rd[0], 32'h3);
    idle(1, 1'b1, 1'b0);
    rdq(1000);
    chk("inj_a_1000", 0, rd[0], 32'h12345679);
    rdq(20);
    chk("inj_a_after", 0, rd[0], 0);
    idle(2);
    chk("inj_b_kept", 1, rd[1], 1);
    idle(3);

    // reset while a read is in flight
    wr(30, 32'hCAFEF00D, 7'h19, 4'hF);
    rdq(30);
    idle(1, 1'b1, 1'b0);
    rst = 1'b1;
    req(1'b1, 1'b1, 30, 32'h0, 7'h00, 4'hF);
    chk("rst_c_rvalid", 2, rv[2], 0);
    chk("rst_c_rdata",  2, rd[2], 0);
    chk("rst_c_wcnt",   2, wc[2], 0);
    chk("rst_c_rcnt",   2, rc[2], 0);
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      idle();
      chk("rst_no_rvalid", 2, rv[2], 0);
    end
    rdq(30);
    idle(3);
    chk("post_rst_valid", 2, rv[2], 1);
    chk("post_rst_data",  2, rd[2], 32'hCAFEF00D);
    chk("post_rst_ecc",   2, re[2], 32'h19);
    chk("post_rst_rcnt",  2, rc[2], 1);
    chk("post_rst_a",     0, rd[0], 32'hCAFEF00D);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
